// File: rtl/seg_display_mux.sv
// Scans four BCD digits (MM.SS) onto a common-anode 7-segment display with colon dot and per-field blink.
// Latency: outputs registered, 1 clk after digit/blink state; no backpressure (free-running scan, inputs sampled once per scan).
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] sec_one,
  input  logic       blink_min,
  input  logic       blink_sec,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
  } time_t;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    d;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  time_t         snapshot;

  logic          refresh_wrap;
  logic          scan_wrap;
  logic          blink_wrap;
  logic [3:0]    cur_digit;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign refresh_wrap = (refresh_cnt == REFRESH_LAST);
  assign scan_wrap    = refresh_wrap && (d == 2'd3);
  assign blink_wrap   = (blink_cnt == BLINK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      d           <= 2'd0;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
      if (refresh_wrap) d <= d + 2'd1;
    end
  end

  // Snapshot on the 3->0 edge so a carry never tears across one scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snapshot <= '0;
    end else if (scan_wrap) begin
      snapshot <= '{min_ten: min_ten, min_one: min_one, sec_ten: sec_ten, sec_one: sec_one};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) blink_phase <= ~blink_phase;
    end
  end

  always_comb begin
    cur_digit = snapshot.sec_one;
    case (d)
      2'd0:    cur_digit = snapshot.sec_one;
      2'd1:    cur_digit = snapshot.sec_ten;
      2'd2:    cur_digit = snapshot.min_one;
      default: cur_digit = snapshot.min_ten;
    endcase
  end

  // d[1] selects the minute pair; blink inputs act live, not via the snapshot.
  assign blank = blink_phase && ((d[1] && blink_min) || (!d[1] && blink_sec));

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (!blank) begin
      an_nxt[d] = 1'b0;
      seg_nxt   = bcd_to_seg(cur_digit);
      dp_nxt    = (d != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with an arithmetic reference model checked every cycle.
module tb_seg_display_mux;
  localparam int R = 4;
  localparam int B = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic       blink_min, blink_sec;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  seg_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset),
    .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
    .blink_min(blink_min), .blink_sec(blink_sec),
    .seg(seg), .dp(dp), .an(an)
  );

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Model: n = edges since reset release; digit and blink phase follow by division.
  int unsigned n;
  int unsigned dd;
  bit          ph;
  bit          mblank;
  logic [3:0]  msnap [4];
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
    end else begin
      dd = (n / R) % 4;
      ph = ((n / B) % 2) == 1;
      mblank = ph && ((dd >= 2 && blink_min) || (dd <= 1 && blink_sec));
      if (mblank) begin
        exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
      end else begin
        exp_an = 4'b1111;
        exp_an[dd] = 1'b0;
        exp_seg = glyph(msnap[dd]);
        exp_dp = (dd != 2);
      end
      if ((n % (4 * R)) == (4 * R - 1)) begin
        msnap[0] = sec_one; msnap[1] = sec_ten; msnap[2] = min_one; msnap[3] = min_ten;
      end
      n++;
    end
  end

  task automatic check(input string name, input logic [3:0] a, input logic [6:0] s, input logic p);
    total++;
    if (an !== a || seg !== s || dp !== p) begin
      bad++;
      $display("FAIL %s @%0t: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               name, $time, an, seg, dp, a, s, p);
    end
  endtask

  always @(negedge clk) if (run_cmp) check("model", exp_an, exp_seg, exp_dp);

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_time(input logic [15:0] t);
    {min_ten, min_one, sec_ten, sec_one} = t;
  endtask

  initial begin
    reset = 1'b1;
    set_time(16'h1234);
    blink_min = 1'b0;
    blink_sec = 1'b0;
    #2 reset = 1'b0;
    #1 run_cmp = 1'b1;
    tick(3);
    check("reset_hold", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b1;
    tick(1);   // edge 1
    check("first_digit", 4'b1110, 7'b1000000, 1'b1);
    tick(16);  // edge 17: 12:34 visible
    check("scan_d0_4", 4'b1110, 7'b0011001, 1'b1);
    tick(4);
    check("scan_d1_3", 4'b1101, 7'b0110000, 1'b1);
    tick(4);
    check("scan_d2_2_colon", 4'b1011, 7'b0100100, 1'b0);
    tick(4);   // edge 29
    check("scan_d3_1", 4'b0111, 7'b1111001, 1'b1);
    set_time(16'h0959);
    tick(9);   // edge 38, d=1 of the 09:59 scan
    set_time(16'h1000);
    tick(3);   // edge 41
    check("coherent_d2_9", 4'b1011, 7'b0010000, 1'b0);
    tick(4);
    check("coherent_d3_0", 4'b0111, 7'b1000000, 1'b1);
    tick(4);   // edge 49
    check("next_scan_d0_0", 4'b1110, 7'b1000000, 1'b1);
    tick(12);  // edge 61
    check("next_scan_d3_1", 4'b0111, 7'b1111001, 1'b1);
    blink_min = 1'b1;
    tick(4);   // edge 65: first off-phase edge
    check("blink_sec_shown", 4'b1110, 7'b1000000, 1'b1);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (an[3:2] !== 2'b11 || dp !== 1'b1) begin
        bad++;
        $display("FAIL blink_min_off @%0t: got an=%b dp=%b want an[3:2]=11 dp=1", $time, an, dp);
      end
      if (i == 8) check("blink_min_blank", 4'b1111, 7'b1111111, 1'b1);
      tick(1);
    end
    tick(8);   // edge 137, on-phase
    check("blink_on_phase", 4'b1011, 7'b1000000, 1'b0);
    blink_min = 1'b0;
    set_time(16'h100C);
    tick(8);   // edge 145
    check("invalid_dash", 4'b1110, 7'b0111111, 1'b1);
    tick(4);
    check("invalid_other", 4'b1101, 7'b1000000, 1'b1);
    tick(4);   // edge 153: state d=2, cnt=1
    check("pre_reset_d2", 4'b1011, 7'b1000000, 1'b0);
    #2 reset = 1'b0;
    #1 check("async_reset_off", 4'b1111, 7'b1111111, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("restart_d0", 4'b1110, 7'b1000000, 1'b1);
    tick(16);
    check("restart_snapshot", 4'b1110, 7'b0111111, 1'b1);
    tick(4);
    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Downstream display stage for the minutes/seconds BCD counter.
- Consumes the four BCD digits `min_ten`, `min_one`, `sec_ten` and `sec_one`.
- Time-multiplexes them onto a 4-digit common-anode 7-segment display, with a colon dot between minutes and seconds.
- Blinks the minute pair or second pair while that field is being adjusted.
- Inputs are snapshotted once per full scan, so a carry (e.g. 09:59 -> 10:00) never shows mixed digits within one scan.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is driven before advancing (minimum 2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- min_ten  input  4  BCD minutes tens.
- min_one  input  4  BCD minutes ones.
- sec_ten  input  4  BCD seconds tens.
- sec_one  input  4  BCD seconds ones.
- blink_min  input  1  1 = blank minute digits during blink-off phase.
- blink_sec  input  1  1 = blank second digits during blink-off phase.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] = rightmost digit.

Behaviour:
- Reset (reset=0, asynchronous):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - refresh_cnt=0, digit index d=0, blink_cnt=0, blink_phase=0, snapshot={0,0,0,0}.
- Refresh counter (width clog2(REFRESH_DIV)):
  - Increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and d advances 0->1->2->3->0 (2-bit wrap).
- Snapshot: on the same edge where d goes 3->0, all four inputs load into the snapshot register. The display never reads the inputs directly.
- The first scan after reset shows 00:00.
- Digit map:
  - d=0: sec_one, an[0].
  - d=1: sec_ten, an[1].
  - d=2: min_one, an[2], dp lit (colon).
  - d=3: min_ten, an[3].
- Blink counter:
  - Counts 0..BLINK_DIV-1 and toggles blink_phase on wrap.
  - blink_phase=1 is the off phase.
  - It is free-running and independent of blink_min/blink_sec.
- Blanking:
  - A digit is blanked when (d>=2 && blink_min && blink_phase) or (d<=1 && blink_sec && blink_phase).
  - blink_min and blink_sec are used live, not snapshotted.
  - Blanked digit: an all 1, seg=7'b1111111, dp=1.
- Decode (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10-15 (invalid BCD) show a dash: 0111111.
- Output registering:
  - an, seg and dp are registered; at edge k they reflect d, snapshot, blink state and blink inputs as they stood before edge k.
  - Exactly one an bit is low per cycle, or none when blanked or in reset.
  - No glitch on a d change: an and seg update on the same edge.
- dp is 0 only for unblanked d=2; otherwise 1.
- Reset asserted mid-scan: outputs go off immediately (asynchronous). After release, scanning restarts at d=0 with snapshot 0.
- Input change mid-scan: invisible until the next 3->0 transition.

Test Plan:
- Reset: hold reset=0 with nonzero inputs -> an=1111, seg=1111111, dp=1. Release -> first edge gives an=1110, seg=1000000 (digit 0).
- Scan order, with REFRESH_DIV=4, BLINK_DIV=64, inputs 12:34, after the first snapshot:
  - an cycles 1110/1101/1011/0111, each for 4 cycles.
  - seg = 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
  - dp=0 only while an=1011.
- Coherence: change inputs 09:59 -> 10:00 while d=1 -> rest of scan still shows 09:59. The next scan shows 10:00 on all digits.
- Blink: blink_min=1, blink_sec=0 -> in blink_phase=1, an[3:2] never go low and dp stays 1. Seconds digits are unaffected. In blink_phase=0 all four digits are shown.
- Invalid BCD: sec_one=4'hC -> digit 0 seg=0111111. Other digits decode normally.
- Async reset mid-digit (d=2, cnt=1): drop reset between clock edges -> outputs go off before the next clk edge. After release, the sequence restarts at an=1110.
